// File: rtl/kmap_pkg.sv
// ============================================================================
// kmap_pkg : shared state encoding and sizing for the K-map sweep controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package kmap_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int N_IN_DEF = 4;
    localparam int TBL_W    = 1 << N_IN_DEF;

endpackage

`default_nettype wire

// File: rtl/kmap_settle_cnt.sv
// ============================================================================
// kmap_settle_cnt : settle-time counter; tc_o marks the sample cycle of a code
// Revision : 1.0
// ============================================================================
`default_nettype none

module kmap_settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [CW-1:0] cnt_q;

    assign tc_o = (cnt_q == CW'(SETTLE - 1));

    // Wraps to zero on the terminal count so the next code starts a fresh window
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tc_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/kmap_sweep_ctrl.sv
// ============================================================================
// kmap_sweep_ctrl : sweeps all input codes of a K-map function and checks it
// Revision : 1.0
// ============================================================================
`default_nettype none

module kmap_sweep_ctrl
    import kmap_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [(1<<N_IN)-1:0]   expected_i,
    output logic [N_IN-1:0]        x_o,
    input  logic                   func_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [(1<<N_IN)-1:0]   table_o,
    output logic [(1<<N_IN)-1:0]   mismatch_o,
    output logic                   pass_o
);

    state_t                 state_q;
    logic [N_IN-1:0]        x_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic [(1<<N_IN)-1:0]   tbl_q;
    logic [(1<<N_IN)-1:0]   mis_q;
    logic [(1<<N_IN)-1:0]   exp_q;
    logic                   settle_tc;
    logic                   sample_strobe;

    kmap_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != S_WAIT),
        .en_i  (state_q == S_WAIT),
        .tc_o  (settle_tc)
    );

    assign sample_strobe = (state_q == S_WAIT) && settle_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tbl_q   <= '0;
            mis_q   <= '0;
            exp_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        exp_q   <= expected_i;
                        tbl_q   <= '0;
                        mis_q   <= '0;
                        pass_q  <= 1'b0;
                        x_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sample_strobe) begin
                        tbl_q[x_q] <= func_i;
                        // The sweep ends on the all-ones code; x never wraps
                        if (&x_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            x_q <= x_q + N_IN'(1);
                        end
                    end
                end
                S_DONE: begin
                    mis_q   <= tbl_q ^ exp_q;
                    pass_q  <= (tbl_q == exp_q);
                    busy_q  <= 1'b0;
                    x_q     <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign x_o        = x_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign table_o    = tbl_q;
    assign mismatch_o = mis_q;
    assign pass_o     = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_kmap_sweep_ctrl.sv
// ============================================================================
// tb_kmap_sweep_ctrl : scoreboard bench for kmap_sweep_ctrl (SETTLE 1 and 3)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_kmap_sweep_ctrl;

    typedef struct {
        logic [15:0] tbl;
        logic [15:0] mis;
        logic        pass;
        int          dcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        start_a, start_b;
    logic [15:0] exp_a, exp_b;
    logic [3:0]  x_a, x_b;
    logic        func_a, func_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] tbl_a, tbl_b, mis_a, mis_b;

    logic [15:0] f_tbl = 16'h6996;
    int          mode = 0;
    logic [1:0]  da, db;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb, es;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function under test: either a truth-table lookup or parity through two registers
    always @(posedge clk) begin
        if (rst) begin
            da <= 2'b00;
            db <= 2'b00;
        end else begin
            da <= {da[0], ^x_a};
            db <= {db[0], ^x_b};
        end
    end
    assign func_a = (mode == 2) ? da[1] : f_tbl[x_a];
    assign func_b = db[1];

    kmap_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .expected_i(exp_a), .x_o(x_a),
        .func_i(func_a), .busy_o(busy_a), .done_o(done_a), .table_o(tbl_a),
        .mismatch_o(mis_a), .pass_o(pass_a)
    );

    kmap_sweep_ctrl #(.N_IN(4), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .expected_i(exp_b), .x_o(x_b),
        .func_i(func_b), .busy_o(busy_b), .done_o(done_b), .table_o(tbl_b),
        .mismatch_o(mis_b), .pass_o(pass_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Sampled code k at edge k+1 sees parity of the code two edges earlier (0 while idle)
    function automatic logic [15:0] dly_model();
        logic [15:0] t;
        logic [3:0]  c;
        t = '0;
        for (int k = 2; k < 16; k++) begin
            c = 4'(k - 2);
            t[k] = ^c;
        end
        return t;
    endfunction

    always @(negedge clk) begin
        if (!rst && done_a) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done_a: got pulse expected none");
            end else begin
                ea = qa.pop_front();
                chk("done_cycle_a", 32'(cyc), 32'(ea.dcyc));
                chk("table_a", 32'(tbl_a), 32'(ea.tbl));
                @(posedge clk);
                #1;
                chk("mismatch_a", 32'(mis_a), 32'(ea.mis));
                chk("pass_a", 32'(pass_a), 32'(ea.pass));
                chk("done_pulse_a", 32'(done_a), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done_b) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done_b: got pulse expected none");
            end else begin
                eb = qb.pop_front();
                chk("done_cycle_b", 32'(cyc), 32'(eb.dcyc));
                chk("table_b", 32'(tbl_b), 32'(eb.tbl));
                @(posedge clk);
                #1;
                chk("mismatch_b", 32'(mis_b), 32'(eb.mis));
                chk("pass_b", 32'(pass_b), 32'(eb.pass));
            end
        end
    end

    task automatic run_a(input logic [15:0] expv, input logic [15:0] tblv, input bit extra);
        @(negedge clk);
        start_a = 1'b1;
        exp_a   = expv;
        es.tbl  = tblv;
        es.mis  = tblv ^ expv;
        es.pass = (tblv == expv);
        es.dcyc = cyc + 17;
        qa.push_back(es);
        for (int m = 0; m <= 16; m++) begin
            @(negedge clk);
            start_a = extra && (m == 4 || m == 16);
            if (m < 16) begin
                chk("x_step_a", 32'(x_a), 32'(m));
                chk("busy_a", 32'(busy_a), 32'd1);
            end
        end
        @(negedge clk);
        start_a = 1'b0;
        exp_a   = 16'($urandom);
        repeat (2) @(negedge clk);
        chk("idle_a", 32'(busy_a), 32'd0);
        if (extra) begin
            repeat (20) @(negedge clk);
            chk("no_restart_a", 32'(busy_a), 32'd0);
        end
    endtask

    task automatic run_b(input logic [15:0] expv, input logic [15:0] tblv);
        @(negedge clk);
        start_b = 1'b1;
        exp_b   = expv;
        es.tbl  = tblv;
        es.mis  = tblv ^ expv;
        es.pass = (tblv == expv);
        es.dcyc = cyc + 49;
        qb.push_back(es);
        for (int m = 0; m <= 48; m++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (m < 48) chk("x_step_b", 32'(x_b), 32'(m / 3));
        end
        repeat (3) @(negedge clk);
        chk("idle_b", 32'(busy_b), 32'd0);
    endtask

    initial begin
        logic [15:0] ev;
        start_a = 1'b0;
        start_b = 1'b0;
        exp_a   = '0;
        exp_b   = '0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_x", 32'(x_a), 32'd0);
        chk("rst_table", 32'(tbl_a), 32'd0);
        chk("rst_mismatch", 32'(mis_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);

        run_a(16'h6996, 16'h6996, 1'b0);
        run_a(16'h6997, 16'h6996, 1'b0);
        run_a(16'h6996, 16'h6996, 1'b1);

        // Reset part-way through a sweep, then a clean restart
        @(negedge clk);
        start_a = 1'b1;
        exp_a   = 16'h6996;
        repeat (8) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_x", 32'(x_a), 32'd0);
        chk("midrst_table", 32'(tbl_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_done", 32'(done_a), 32'd0);
        chk("midrst_pass", 32'(pass_a), 32'd0);
        rst = 1'b0;
        run_a(16'h6996, 16'h6996, 1'b0);

        for (int i = 0; i < 6; i++) begin
            f_tbl = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       ev = f_tbl;
                1:       ev = f_tbl ^ (16'h1 << $urandom_range(0, 15));
                default: ev = 16'($urandom);
            endcase
            run_a(ev, f_tbl, 1'b0);
        end

        mode = 2;
        run_a(16'h6996, dly_model(), 1'b0);
        run_b(16'h6996, 16'h6996);
        run_b(16'h6997, 16'h6996);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(qa.size() + qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
